// File: rtl/axis_cmd_splitter.sv
// Splits {addr, len} transfer commands into bursts bounded by MAX_BURST and BOUNDARY.
// Optional statistics counters: define AXIS_CMD_SPLITTER_STAT_EN.
module axis_cmd_splitter #(
    parameter int unsigned MAX_BURST = 4096,
    parameter int unsigned BOUNDARY  = 4096
) (
    input  logic        ap_clk,
    input  logic        resetn,
    input  logic [95:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [95:0] out_tdata,
    output logic        out_tuser,
    output logic        out_tvalid,
    input  logic        out_tready
`ifdef AXIS_CMD_SPLITTER_STAT_EN
    ,
    output logic [31:0] stat_cmd_cnt,
    output logic [31:0] stat_burst_cnt,
    output logic [15:0] stat_drop_cnt
`endif
);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t      state;
    logic [63:0] addr;
    logic [31:0] rem;

    logic        shift_en;
    logic        accept;
    logic [63:0] in_addr;
    logic [31:0] in_len;
    logic [31:0] in_chunk;
    logic [31:0] sp_chunk;

    // room is at most 2^31, so 33 bits cover every min() operand
    function automatic logic [31:0] chunk_of(
        input logic [63:0] a,
        input logic [31:0] r
    );
        logic [32:0] room;
        logic [32:0] c;
        room = 33'(BOUNDARY) - {1'b0, a[31:0] & 32'(BOUNDARY - 1)};
        c    = {1'b0, r};
        if (33'(MAX_BURST) < c) c = 33'(MAX_BURST);
        if (room < c) c = room;
        return c[31:0];
    endfunction

    assign shift_en  = ~out_tvalid | out_tready;
    assign in_tready = (state == IDLE) & shift_en & resetn;
    assign accept    = in_tvalid & in_tready;
    assign in_addr   = in_tdata[63:0];
    assign in_len    = in_tdata[95:64];
    assign in_chunk  = chunk_of(in_addr, in_len);
    assign sp_chunk  = chunk_of(addr, rem);

    always_ff @(posedge ap_clk) begin
        if (!resetn) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            out_tdata  <= '0;
            out_tuser  <= 1'b0;
            out_tvalid <= 1'b0;
        end else if (shift_en) begin
            unique case (state)
                IDLE: begin
                    if (accept && in_len != 32'd0) begin
                        out_tdata  <= {in_chunk, in_addr};
                        out_tuser  <= (in_chunk == in_len);
                        out_tvalid <= 1'b1;
                        if (in_chunk != in_len) begin
                            addr  <= in_addr + {32'd0, in_chunk};
                            rem   <= in_len - in_chunk;
                            state <= SPLIT;
                        end
                    end else begin
                        out_tvalid <= 1'b0;
                    end
                end
                SPLIT: begin
                    out_tdata  <= {sp_chunk, addr};
                    out_tuser  <= (sp_chunk == rem);
                    out_tvalid <= 1'b1;
                    addr       <= addr + {32'd0, sp_chunk};
                    rem        <= rem - sp_chunk;
                    if (sp_chunk == rem) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_CMD_SPLITTER_STAT_EN
    always_ff @(posedge ap_clk) begin
        if (!resetn) begin
            stat_cmd_cnt   <= '0;
            stat_burst_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            if (accept && in_len != 32'd0) stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
            if (accept && in_len == 32'd0) stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if (out_tvalid && out_tready) stat_burst_cnt <= stat_burst_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_cmd_splitter.sv
// Directed bench for axis_cmd_splitter (default 4096/4096 parameters).
// Stat checks are compiled in when AXIS_CMD_SPLITTER_STAT_EN is defined.
module tb_axis_cmd_splitter;

    logic        ap_clk;
    logic        resetn;
    logic [95:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic [95:0] out_tdata;
    logic        out_tuser;
    logic        out_tvalid;
    logic        out_tready;
`ifdef AXIS_CMD_SPLITTER_STAT_EN
    logic [31:0] stat_cmd_cnt;
    logic [31:0] stat_burst_cnt;
    logic [15:0] stat_drop_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [96:0] bq[$];
    int          bc[$];
    int          accq[$];
    int          rdy_viol;
    bit          vld_seen;

    axis_cmd_splitter #(
        .MAX_BURST(4096),
        .BOUNDARY (4096)
    ) dut (
        .ap_clk    (ap_clk),
        .resetn    (resetn),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tuser (out_tuser),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready)
`ifdef AXIS_CMD_SPLITTER_STAT_EN
        ,
        .stat_cmd_cnt  (stat_cmd_cnt),
        .stat_burst_cnt(stat_burst_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Inputs change only at posedge+1, so negedge sees what the next edge will use
    always @(negedge ap_clk) begin
        if (resetn === 1'b1) begin
            if (out_tvalid && out_tready) begin
                bq.push_back({out_tuser, out_tdata});
                bc.push_back(cyc);
            end
            if (in_tvalid && in_tready) accq.push_back(cyc);
            if (out_tvalid && !out_tuser && in_tready) rdy_viol++;
            if (out_tvalid) vld_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        bq.delete();
        bc.delete();
        accq.delete();
        rdy_viol = 0;
        vld_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
        bit got;
        int n;
        in_tdata  = {l, a};
        in_tvalid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge ap_clk);
            got = in_tready;
            @(posedge ap_clk);
            #1;
            n++;
        end
        in_tvalid = 1'b0;
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout addr=%h len=%h got=0 want=1", a, l);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        checks++;
        if (out_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL rst_tvalid got=%b want=0", out_tvalid);
        end
        checks++;
        if (out_tdata !== 96'd0 || out_tuser !== 1'b0) begin
            fails++;
            $display("FAIL rst_data got=%h/%b want=0/0", out_tdata, out_tuser);
        end
        checks++;
        if (in_tready !== 1'b0) begin
            fails++;
            $display("FAIL rst_ready got=%b want=0", in_tready);
        end
        @(posedge ap_clk);
        #1;
        resetn = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (in_tready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready got=%b want=1", in_tready);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_cmd(64'h40, 32'h0);
        idle(5);
        checks++;
        if (vld_seen !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_tvalid got=%b want=0", vld_seen);
        end
`ifdef AXIS_CMD_SPLITTER_STAT_EN
        checks++;
        if (stat_drop_cnt !== 16'd1 || stat_cmd_cnt !== 32'd0) begin
            fails++;
            $display("FAIL zero_len_stats got=%0d/%0d want=1/0",
                     stat_drop_cnt, stat_cmd_cnt);
        end
`endif
    endtask

    task automatic test_single();
        clear_mon();
        send_cmd(64'h0, 32'h100);
        idle(4);
        checks++;
        if (bq.size() !== 1 || bq[0] !== {1'b1, 32'h100, 64'h0}) begin
            fails++;
            $display("FAIL single_burst got n=%0d %h want n=1 %h",
                     bq.size(), (bq.size() > 0) ? bq[0] : 97'd0,
                     {1'b1, 32'h100, 64'h0});
        end
        checks++;
        if (bc.size() !== 1 || accq.size() !== 1 || bc[0] !== accq[0] + 1) begin
            fails++;
            $display("FAIL single_latency got=%0d want=1",
                     (bc.size() > 0 && accq.size() > 0) ? bc[0] - accq[0] : -1);
        end
`ifdef AXIS_CMD_SPLITTER_STAT_EN
        checks++;
        if (stat_cmd_cnt !== 32'd1 || stat_burst_cnt !== 32'd1) begin
            fails++;
            $display("FAIL single_stats got=%0d/%0d want=1/1",
                     stat_cmd_cnt, stat_burst_cnt);
        end
`endif
    endtask

    task automatic test_boundary();
        logic [96:0] exp[2];
        exp[0] = {1'b0, 32'h100, 64'hF00};
        exp[1] = {1'b1, 32'h200, 64'h1000};
        clear_mon();
        send_cmd(64'hF00, 32'h300);
        idle(5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== exp[i]) begin
                fails++;
                $display("FAIL boundary_burst%0d got=%h want=%h", i,
                         (i < bq.size()) ? bq[i] : 97'd0, exp[i]);
            end
        end
        checks++;
        if (bc.size() !== 2 || bc[1] !== bc[0] + 1) begin
            fails++;
            $display("FAIL boundary_gap got n=%0d want consecutive", bc.size());
        end
        checks++;
        if (rdy_viol !== 0) begin
            fails++;
            $display("FAIL boundary_ready got=%0d want=0", rdy_viol);
        end
    endtask

    task automatic test_addr_wrap();
        logic [96:0] exp[2];
        exp[0] = {1'b0, 32'h100, 64'hFFFF_FFFF_FFFF_FF00};
        exp[1] = {1'b1, 32'h100, 64'h0};
        clear_mon();
        send_cmd(64'hFFFF_FFFF_FFFF_FF00, 32'h200);
        idle(5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== exp[i]) begin
                fails++;
                $display("FAIL wrap_burst%0d got=%h want=%h", i,
                         (i < bq.size()) ? bq[i] : 97'd0, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [96:0] exp[4];
        exp[0] = {1'b0, 32'h1000, 64'h1000};
        exp[1] = {1'b0, 32'h1000, 64'h2000};
        exp[2] = {1'b1, 32'h800, 64'h3000};
        exp[3] = {1'b1, 32'h80, 64'h20000};
        clear_mon();
        send_cmd(64'h1000, 32'h2800);
        send_cmd(64'h20000, 32'h80);
        idle(6);
        checks++;
        if (bq.size() !== 4) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=4", bq.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== exp[i]) begin
                fails++;
                $display("FAIL b2b_burst%0d got=%h want=%h", i,
                         (i < bq.size()) ? bq[i] : 97'd0, exp[i]);
            end
        end
        checks++;
        if (accq.size() !== 2 || bc.size() !== 4 || accq[1] !== bc[2]
            || bc[3] !== bc[2] + 1 || bc[2] !== bc[0] + 2) begin
            fails++;
            $display("FAIL b2b_timing got acc=%0d bursts=%0d want 2/4 no bubble",
                     accq.size(), bc.size());
        end
        checks++;
        if (rdy_viol !== 0) begin
            fails++;
            $display("FAIL b2b_ready got=%0d want=0", rdy_viol);
        end
    endtask

    task automatic test_backpressure();
        logic [96:0] exp[3];
        int bad;
        exp[0] = {1'b0, 32'h1000, 64'h1000};
        exp[1] = {1'b0, 32'h1000, 64'h2000};
        exp[2] = {1'b1, 32'h800, 64'h3000};
        clear_mon();
        out_tready = 1'b0;
        send_cmd(64'h1000, 32'h2800);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            if (out_tvalid !== 1'b1 || {out_tuser, out_tdata} !== exp[0]
                || in_tready !== 1'b0) bad++;
            @(posedge ap_clk);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL bp_hold got=%0d bad cycles want=0", bad);
        end
        out_tready = 1'b1;
        idle(6);
        checks++;
        if (bq.size() !== 3) begin
            fails++;
            $display("FAIL bp_count got=%0d want=3", bq.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_burst%0d got=%h want=%h", i,
                         (i < bq.size()) ? bq[i] : 97'd0, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [96:0] exp[2];
        clear_mon();
        send_cmd(64'h1000, 32'h2800);
        @(negedge ap_clk);
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        @(posedge ap_clk);
        #1;
        resetn = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (in_tready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_ready got=%b want=0", in_tready);
        end
        @(posedge ap_clk);
        #1;
        resetn = 1'b1;
        vld_seen = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (out_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_tvalid got=%b want=0", out_tvalid);
        end
        idle(4);
        checks++;
        if (bq.size() !== 2 || vld_seen !== 1'b0) begin
            fails++;
            $display("FAIL midrst_flush got n=%0d vld=%b want 2/0",
                     bq.size(), vld_seen);
        end
        exp[0] = {1'b0, 32'h100, 64'hF00};
        exp[1] = {1'b1, 32'h200, 64'h1000};
        clear_mon();
        send_cmd(64'hF00, 32'h300);
        idle(5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== exp[i]) begin
                fails++;
                $display("FAIL midrst_next%0d got=%h want=%h", i,
                         (i < bq.size()) ? bq[i] : 97'd0, exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        rdy_viol   = 0;
        vld_seen   = 1'b0;
        test_reset();
        test_zero_len();
        test_single();
        test_boundary();
        test_addr_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
